// File: rtl/pucch_sched.sv
// rtl/pucch_sched.sv - round-robin arbiter sharing one pucch generator among N_REQ requesters
// Grants one requester at a time, validates its config, starts the generator and supervises the job.
module pucch_sched #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [N_REQ*42-1:0]   i_req_cfg,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic [2:0]            o_pucch_format,
  output logic [3:0]            o_symStart,
  output logic [3:0]            o_nPUCCHSym,
  output logic [1:0]            o_ack,
  output logic [1:0]            o_lenACK,
  output logic                  o_sr,
  output logic                  o_lenSR,
  output logic [3:0]            o_m0,
  output logic [7:0]            o_nslot,
  output logic [9:0]            o_nid,
  output logic [2:0]            o_occi,
  output logic                  o_start,
  input  logic                  i_pucch_valid,
  input  logic                  i_pucch_done,
  output logic                  o_busy,
  output logic [2:0]            o_active_id,
  output logic                  o_done,
  output logic                  o_reject,
  output logic                  o_timeout,
  output logic [7:0]            o_sample_cnt
);

  localparam int CFG_W = 42;
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, CHECK, START, RUN, FIN} state_t;

  state_t            state;
  logic [2:0]        rr_ptr;
  logic [7:0]        cnt;
  logic [7:0]        cnt_next;
  logic [WD_W-1:0]   wd;
  logic [WD_W-1:0]   wd_inc;
  logic              found;
  logic [2:0]        gnt_id;
  logic [N_REQ-1:0]  gnt_oh;
  logic [CFG_W-1:0]  gnt_cfg;
  int                best_off;
  int                off;
  logic [4:0]        sym_end;
  logic              cfg_bad;
  logic [2:0]        next_ptr;

  // Pick the valid requester with the smallest distance from rr_ptr (wrapping).
  always_comb begin
    found    = 1'b0;
    gnt_id   = 3'd0;
    gnt_oh   = '0;
    gnt_cfg  = '0;
    best_off = N_REQ;
    off      = 0;
    for (int j = 0; j < N_REQ; j++) begin
      off = (j >= int'(rr_ptr)) ? j - int'(rr_ptr) : j + N_REQ - int'(rr_ptr);
      if (i_req_valid[j] && off < best_off) begin
        found    = 1'b1;
        best_off = off;
        gnt_id   = 3'(j);
        gnt_oh   = '0;
        gnt_oh[j] = 1'b1;
        gnt_cfg  = i_req_cfg[j*CFG_W +: CFG_W];
      end
    end
  end

  assign sym_end = {1'b0, o_symStart} + {1'b0, o_nPUCCHSym};

  always_comb begin
    cfg_bad = 1'b0;
    case (o_pucch_format)
      3'd0:    cfg_bad = (o_nPUCCHSym == 4'd0) || (o_nPUCCHSym > 4'd2);
      3'd1:    cfg_bad = (o_nPUCCHSym < 4'd4) || (o_nPUCCHSym > 4'd14);
      default: cfg_bad = 1'b1;
    endcase
    if (sym_end > 5'd14 || o_lenACK == 2'd3)
      cfg_bad = 1'b1;
  end

  assign next_ptr = (int'(o_active_id) == N_REQ - 1) ? 3'd0 : o_active_id + 3'd1;
  assign cnt_next = (i_pucch_valid && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
  assign wd_inc   = wd + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rr_ptr         <= 3'd0;
      cnt            <= 8'd0;
      wd             <= '0;
      o_req_ready    <= '0;
      o_pucch_format <= 3'd0;
      o_symStart     <= 4'd0;
      o_nPUCCHSym    <= 4'd0;
      o_ack          <= 2'd0;
      o_lenACK       <= 2'd0;
      o_sr           <= 1'b0;
      o_lenSR        <= 1'b0;
      o_m0           <= 4'd0;
      o_nslot        <= 8'd0;
      o_nid          <= 10'd0;
      o_occi         <= 3'd0;
      o_start        <= 1'b0;
      o_busy         <= 1'b0;
      o_active_id    <= 3'd0;
      o_done         <= 1'b0;
      o_reject       <= 1'b0;
      o_timeout      <= 1'b0;
      o_sample_cnt   <= 8'd0;
    end else begin
      o_req_ready <= '0;
      o_start     <= 1'b0;
      o_done      <= 1'b0;
      o_reject    <= 1'b0;
      o_timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            o_req_ready <= gnt_oh;
            o_active_id <= gnt_id;
            {o_occi, o_nid, o_nslot, o_m0, o_lenSR, o_sr, o_lenACK, o_ack,
             o_nPUCCHSym, o_symStart, o_pucch_format} <= gnt_cfg;
            o_busy      <= 1'b1;
            state       <= CHECK;
          end
        end
        CHECK: begin
          if (cfg_bad) begin
            o_reject <= 1'b1;
            o_busy   <= 1'b0;
            rr_ptr   <= next_ptr;
            state    <= IDLE;
          end else begin
            o_start  <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          cnt   <= 8'd0;
          wd    <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt_next;
          wd  <= wd_inc;
          // done takes priority over a watchdog expiry in the same cycle
          if (i_pucch_done) begin
            o_sample_cnt <= cnt_next;
            o_done       <= 1'b1;
            state        <= FIN;
          end else if (wd_inc == WD_W'(TIMEOUT - 1)) begin
            o_sample_cnt <= cnt_next;
            o_timeout    <= 1'b1;
            o_busy       <= 1'b0;
            rr_ptr       <= next_ptr;
            state        <= IDLE;
          end
        end
        FIN: begin
          o_busy <= 1'b0;
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pucch_sched.sv
// tb/tb_pucch_sched.sv - directed bench for pucch_sched with a stub generator
// Stub emits stub_n valids (done on the last) after each o_start unless stub_hang is set.
module tb_pucch_sched;

  localparam int N  = 4;
  localparam int TO = 40;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*42-1:0] req_cfg;
  logic [N-1:0]    o_req_ready;
  logic [2:0]      o_pucch_format;
  logic [3:0]      o_symStart;
  logic [3:0]      o_nPUCCHSym;
  logic [1:0]      o_ack;
  logic [1:0]      o_lenACK;
  logic            o_sr;
  logic            o_lenSR;
  logic [3:0]      o_m0;
  logic [7:0]      o_nslot;
  logic [9:0]      o_nid;
  logic [2:0]      o_occi;
  logic            o_start;
  logic            pv;
  logic            pd;
  logic            o_busy;
  logic [2:0]      o_active_id;
  logic            o_done;
  logic            o_reject;
  logic            o_timeout;
  logic [7:0]      o_sample_cnt;

  logic [41:0]     cfg_out;
  logic [61:0]     all_out;

  int total = 0;
  int bad   = 0;
  int stub_n = 1;
  bit stub_hang = 1'b0;

  int t_fmt [12] = '{2, 0, 0, 1, 1,  1,  0, 0, 0,  0, 1,  1};
  int t_ss  [12] = '{0, 0, 0, 0, 0, 10, 13, 0, 15, 12, 0, 10};
  int t_sym [12] = '{1, 0, 3, 3, 15, 7,  2, 1, 1,  2, 14, 4};
  int t_la  [12] = '{0, 0, 0, 0, 0,  0,  0, 3, 0,  2, 0,  1};
  int t_rej [12] = '{1, 1, 1, 1, 1,  1,  1, 1, 1,  0, 0,  0};

  always #5 clk = ~clk;

  assign cfg_out = {o_occi, o_nid, o_nslot, o_m0, o_lenSR, o_sr, o_lenACK, o_ack,
                    o_nPUCCHSym, o_symStart, o_pucch_format};
  assign all_out = {o_req_ready, cfg_out, o_start, o_busy, o_active_id, o_done,
                    o_reject, o_timeout, o_sample_cnt};

  pucch_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (req_valid),
    .i_req_cfg      (req_cfg),
    .o_req_ready    (o_req_ready),
    .o_pucch_format (o_pucch_format),
    .o_symStart     (o_symStart),
    .o_nPUCCHSym    (o_nPUCCHSym),
    .o_ack          (o_ack),
    .o_lenACK       (o_lenACK),
    .o_sr           (o_sr),
    .o_lenSR        (o_lenSR),
    .o_m0           (o_m0),
    .o_nslot        (o_nslot),
    .o_nid          (o_nid),
    .o_occi         (o_occi),
    .o_start        (o_start),
    .i_pucch_valid  (pv),
    .i_pucch_done   (pd),
    .o_busy         (o_busy),
    .o_active_id    (o_active_id),
    .o_done         (o_done),
    .o_reject       (o_reject),
    .o_timeout      (o_timeout),
    .o_sample_cnt   (o_sample_cnt)
  );

  function automatic logic [41:0] mk_cfg(input logic [2:0] fmt, input logic [3:0] ss,
                                         input logic [3:0] nsym, input logic [1:0] ack,
                                         input logic [1:0] lenack, input logic sr,
                                         input logic lensr, input logic [3:0] m0,
                                         input logic [7:0] nslot, input logic [9:0] nid,
                                         input logic [2:0] occi);
    return {occi, nid, nslot, m0, lensr, sr, lenack, ack, nsym, ss, fmt};
  endfunction

  initial begin
    pv = 1'b0;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (o_start && !stub_hang) begin
        @(negedge clk);
        for (int j = 0; j < stub_n; j++) begin
          pv = 1'b1;
          pd = (j == stub_n - 1);
          @(negedge clk);
        end
        pv = 1'b0;
        pd = 1'b0;
      end
    end
  end

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (o_req_ready == '0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!o_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '0;
    req_cfg = '0;
    repeat (3) @(negedge clk);
    total++;
    if (all_out !== '0) $display("FAIL reset_outputs got=%h exp=0", all_out);
    if (all_out !== '0) bad++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_req_ready !== '0) begin
      $display("FAIL idle_after_reset busy=%b ready=%b exp 0/0", o_busy, o_req_ready);
      bad++;
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    logic [N-1:0] expv;
    stub_n = 2;
    for (int r = 0; r < N; r++) req_cfg[r*42 +: 42] = mk_cfg(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      wait_ready(cyc);
      expv = 4'b0001 << (g % 4);
      total++;
      if (o_req_ready !== expv) begin
        $display("FAIL rr_grant%0d got=%b exp=%b", g, o_req_ready, expv);
        bad++;
      end
      total++;
      if (o_active_id !== 3'(g % 4)) begin
        $display("FAIL rr_active_id%0d got=%0d exp=%0d", g, o_active_id, g % 4);
        bad++;
      end
      if (g == 4) req_valid = '0;
      @(negedge clk);
    end
    wait_done(cyc);
    total++;
    if (!o_done || o_sample_cnt !== 8'd2) begin
      $display("FAIL rr_last_done done=%b cnt=%0d exp 1/2", o_done, o_sample_cnt);
      bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_format0();
    logic [41:0] cfg;
    cfg = mk_cfg(0, 4, 2, 2'b11, 2, 1, 0, 5, 3, 512, 0);
    stub_n = 24;
    req_cfg[41:0] = cfg;
    req_valid = 4'b0001;
    @(negedge clk);
    total++;
    if (o_req_ready !== 4'b0001 || o_start !== 1'b0) begin
      $display("FAIL f0_grant ready=%b start=%b exp 0001/0", o_req_ready, o_start);
      bad++;
    end
    req_valid = '0;
    @(negedge clk);
    total++;
    if (o_start !== 1'b1 || o_busy !== 1'b1) begin
      $display("FAIL f0_start_latency start=%b busy=%b exp 1/1", o_start, o_busy);
      bad++;
    end
    total++;
    if (cfg_out !== cfg || o_active_id !== 3'd0) begin
      $display("FAIL f0_cfg_out got=%h id=%0d exp=%h id=0", cfg_out, o_active_id, cfg);
      bad++;
    end
    repeat (25) @(negedge clk);
    total++;
    if (o_done !== 1'b1 || o_sample_cnt !== 8'd24) begin
      $display("FAIL f0_done done=%b cnt=%0d exp 1/24", o_done, o_sample_cnt);
      bad++;
    end
    total++;
    if (cfg_out !== cfg) begin
      $display("FAIL f0_cfg_hold got=%h exp=%h", cfg_out, cfg);
      bad++;
    end
    @(negedge clk);
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      $display("FAIL f0_back_idle done=%b busy=%b exp 0/0", o_done, o_busy);
      bad++;
    end
  endtask

  task automatic test_format1();
    int dones;
    int at;
    stub_n = 36;
    req_cfg[41:0] = mk_cfg(1, 4, 7, 2, 2, 0, 0, 0, 0, 0, 1);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    total++;
    if (o_start !== 1'b1) begin
      $display("FAIL f1_start got=%b exp=1", o_start);
      bad++;
    end
    dones = 0;
    at = 0;
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      if (o_done) begin
        dones++;
        at = c;
      end
    end
    total++;
    if (dones != 1 || at != 37) begin
      $display("FAIL f1_done_once count=%0d cycle=%0d exp 1/37", dones, at);
      bad++;
    end
    total++;
    if (o_sample_cnt !== 8'd36) begin
      $display("FAIL f1_sample_cnt got=%0d exp=36", o_sample_cnt);
      bad++;
    end
  endtask

  task automatic test_validation();
    logic exp_rej;
    stub_n = 1;
    for (int e = 0; e < 12; e++) begin
      exp_rej = (t_rej[e] != 0);
      req_cfg[41:0] = mk_cfg(3'(t_fmt[e]), 4'(t_ss[e]), 4'(t_sym[e]), 0, 2'(t_la[e]),
                             0, 0, 0, 0, 0, 0);
      req_valid = 4'b0001;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      total++;
      if (o_reject !== exp_rej || o_start !== !exp_rej) begin
        $display("FAIL check_entry%0d reject=%b start=%b exp reject=%b", e, o_reject,
                 o_start, exp_rej);
        bad++;
      end
      if (!exp_rej) begin
        repeat (2) @(negedge clk);
        total++;
        if (o_done !== 1'b1) begin
          $display("FAIL check_entry%0d_done got=%b exp=1", e, o_done);
          bad++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reject_rr();
    int cyc;
    stub_n = 1;
    req_cfg[1*42 +: 42] = mk_cfg(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    req_cfg[3*42 +: 42] = mk_cfg(1, 10, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    req_valid = 4'b0010;
    @(negedge clk);
    total++;
    if (o_req_ready !== 4'b0010) begin
      $display("FAIL rej_grant got=%b exp=0010", o_req_ready);
      bad++;
    end
    req_valid = '0;
    @(negedge clk);
    total++;
    if (o_reject !== 1'b1 || o_start !== 1'b0 || o_busy !== 1'b0) begin
      $display("FAIL rej_pulse reject=%b start=%b busy=%b exp 1/0/0", o_reject, o_start,
               o_busy);
      bad++;
    end
    req_valid = 4'b1010;
    @(negedge clk);
    total++;
    if (o_req_ready !== 4'b1000) begin
      $display("FAIL rej_rr_advance got=%b exp=1000", o_req_ready);
      bad++;
    end
    req_valid = '0;
    wait_done(cyc);
    total++;
    if (o_done !== 1'b1) begin
      $display("FAIL rej_next_job_done got=%b exp=1", o_done);
      bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int tcount;
    int tat;
    int dones;
    int cyc;
    stub_hang = 1'b1;
    req_cfg[2*42 +: 42] = mk_cfg(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    req_valid = 4'b0100;
    @(negedge clk);
    total++;
    if (o_req_ready !== 4'b0100) begin
      $display("FAIL to_grant got=%b exp=0100", o_req_ready);
      bad++;
    end
    req_valid = '0;
    @(negedge clk);
    tcount = 0;
    tat = 0;
    dones = 0;
    for (int c = 1; c <= TO + 3; c++) begin
      @(negedge clk);
      if (o_timeout) begin
        tcount++;
        tat = c;
      end
      if (o_done) dones++;
    end
    total++;
    if (tcount != 1 || tat != TO || dones != 0) begin
      $display("FAIL to_pulse count=%0d cycle=%0d dones=%0d exp 1/%0d/0", tcount, tat,
               dones, TO);
      bad++;
    end
    total++;
    if (o_busy !== 1'b0) begin
      $display("FAIL to_idle busy=%b exp=0", o_busy);
      bad++;
    end
    stub_hang = 1'b0;
    stub_n = 3;
    req_cfg[3*42 +: 42] = mk_cfg(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    req_valid = 4'b1000;
    wait_ready(cyc);
    total++;
    if (o_req_ready !== 4'b1000) begin
      $display("FAIL to_next_grant got=%b exp=1000", o_req_ready);
      bad++;
    end
    req_valid = '0;
    wait_done(cyc);
    total++;
    if (o_done !== 1'b1 || o_sample_cnt !== 8'd3) begin
      $display("FAIL to_next_done done=%b cnt=%0d exp 1/3", o_done, o_sample_cnt);
      bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    stub_hang = 1'b1;
    req_cfg[1*42 +: 42] = mk_cfg(1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    req_cfg[2*42 +: 42] = mk_cfg(0, 4, 2, 2'b11, 2, 1, 1, 5, 3, 512, 2);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    total++;
    if (o_busy !== 1'b1 || o_active_id !== 3'd2) begin
      $display("FAIL mid_run_state busy=%b id=%0d exp 1/2", o_busy, o_active_id);
      bad++;
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (all_out !== '0) begin
      $display("FAIL async_reset_outputs got=%h exp=0", all_out);
      bad++;
    end
    req_valid = 4'b0110;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stub_hang = 1'b0;
    stub_n = 2;
    @(negedge clk);
    total++;
    if (o_req_ready !== 4'b0010) begin
      $display("FAIL regrant_after_reset got=%b exp=0010", o_req_ready);
      bad++;
    end
    req_valid = '0;
    wait_done(cyc);
    total++;
    if (o_done !== 1'b1 || o_sample_cnt !== 8'd2) begin
      $display("FAIL post_reset_done done=%b cnt=%0d exp 1/2", o_done, o_sample_cnt);
      bad++;
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_format0();
    test_format1();
    test_validation();
    test_reject_rr();
    test_timeout();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

endmodule
